// File: rtl/inst_prefetch_bridge_pkg.sv
// rtl/inst_prefetch_bridge_pkg.sv - shared bus widths, fetch increment and FSM encoding for the prefetch bridge
package inst_prefetch_bridge_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;
    localparam int INST_BYTES    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pf_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/inst_prefetch_bridge_ifq_fifo.sv
// rtl/inst_prefetch_bridge_ifq_fifo.sv - DEPTH-entry circular {addr,data} instruction queue with flush
module ifq_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [DATA_W-1:0]        head_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign count     = wr_ptr - rd_ptr;
    assign head_addr = addr_mem[rd_ptr[IDX_W-1:0]];
    assign head_data = data_mem[rd_ptr[IDX_W-1:0]];

    // A simultaneous pop frees the head slot, so a push into a full queue is legal then.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr[IDX_W-1:0]] <= push_addr;
            data_mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/inst_prefetch_bridge.sv
// rtl/inst_prefetch_bridge.sv - sequential instruction prefetcher between core fetch port and pipelined memory
// Optional statistics counters: INST_PREFETCH_STATS_EN
module inst_prefetch_bridge
    import inst_prefetch_bridge_pkg::*;
#(
    parameter int ADDR_W     = INST_ADDR_BUS,
    parameter int DATA_W     = INST_BUS,
    parameter int DEPTH      = 4,
    parameter int MEM_LAT    = 2,
    parameter int INST_BYTES = inst_prefetch_bridge_pkg::INST_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_valid,
    output logic [DATA_W-1:0] core_data,
    output logic              core_stall,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       redir_cnt
);

    pf_state_e          state;
    pf_state_e          state_next;
    logic [ADDR_W-1:0]  pf_addr;
    logic [MEM_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0]  pipe_addr [MEM_LAT];

    logic               q_full;
    logic               q_empty;
    logic [$clog2(DEPTH):0] q_count;
    logic [ADDR_W-1:0]  q_head_addr;
    logic [DATA_W-1:0]  q_head_data;

    logic               hit;
    logic               redirect;
    logic               issue;
    logic [31:0]        inflight;
    logic [31:0]        occ_after;
    logic [ADDR_W-1:0]  expect_addr;

    ifq_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ifq (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_vld[MEM_LAT-1]),
        .push_addr (pipe_addr[MEM_LAT-1]),
        .push_data (mem_data),
        .pop       (hit),
        .flush     (redirect),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head_addr (q_head_addr),
        .head_data (q_head_data)
    );

    // The outstanding read closest to returning is the next address the core may legally ask for.
    always_comb begin
        inflight    = 32'(mem_en);
        expect_addr = pf_addr;
        if (mem_en) expect_addr = mem_addr;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + 32'(pipe_vld[i]);
            if (pipe_vld[i]) expect_addr = pipe_addr[i];
        end
        if (!q_empty) expect_addr = q_head_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ST_IDLE && redirect) state_next = ST_RUN;
    end

    always_comb begin
        hit        = 1'b0;
        redirect   = 1'b0;
        issue      = 1'b0;
        occ_after  = 32'(q_count);
        if (rst && core_req) begin
            if (state == ST_IDLE)                              redirect = 1'b1;
            else if (!q_empty && q_head_addr == core_addr)     hit      = 1'b1;
            else if (core_addr != expect_addr)                 redirect = 1'b1;
        end
        occ_after  = 32'(q_count) - 32'(hit);
        if (rst && state == ST_RUN && !redirect && (occ_after + inflight + 32'd1) <= 32'(DEPTH))
            issue = 1'b1;
        core_valid = hit;
        core_data  = hit ? q_head_data : '0;
        core_stall = rst && core_req && !hit;
    end

    // A redirect issues the target directly so the new stream starts one cycle sooner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_en   <= 1'b0;
            mem_addr <= '0;
            pf_addr  <= '0;
            pipe_vld <= '0;
        end else if (redirect) begin
            mem_en   <= 1'b1;
            mem_addr <= core_addr;
            pf_addr  <= core_addr + ADDR_W'(INST_BYTES);
            pipe_vld <= '0;
        end else begin
            mem_en <= issue;
            if (issue) begin
                mem_addr <= pf_addr;
                pf_addr  <= pf_addr + ADDR_W'(INST_BYTES);
            end
            pipe_vld[0] <= mem_en;
            for (int i = 1; i < MEM_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_addr[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
    end

`ifdef INST_PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt   <= '0;
            redir_cnt <= '0;
        end else begin
            if (hit)      hit_cnt   <= sat_inc16(hit_cnt);
            if (redirect) redir_cnt <= sat_inc16(redir_cnt);
        end
    end
`else
    assign hit_cnt   = '0;
    assign redir_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_prefetch_bridge.sv
// tb/tb_inst_prefetch_bridge.sv - scoreboard bench for inst_prefetch_bridge with a fixed-latency memory model
module tb_inst_prefetch_bridge;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 4;
    localparam int MEM_LAT    = 2;
    localparam int INST_BYTES = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              core_req = 1'b0;
    logic [ADDR_W-1:0] core_addr = '0;
    logic              core_valid;
    logic [DATA_W-1:0] core_data;
    logic              core_stall;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [15:0]       hit_cnt;
    logic [15:0]       redir_cnt;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_hits = 0;
    int          n_redir = 0;
    logic [31:0] exp_q [$];

    inst_prefetch_bridge #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .MEM_LAT    (MEM_LAT),
        .INST_BYTES (INST_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_valid (core_valid),
        .core_data  (core_data),
        .core_stall (core_stall),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .hit_cnt    (hit_cnt),
        .redir_cnt  (redir_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: data for the address strobed in cycle t is presented during cycle t+MEM_LAT.
    logic [31:0]        m_addr [MEM_LAT];
    logic [MEM_LAT-1:0] m_vld = '0;
    always @(posedge clk) begin
        m_vld[0]  <= mem_en;
        m_addr[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            m_vld[i]  <= m_vld[i-1];
            m_addr[i] <= m_addr[i-1];
        end
    end
    assign mem_data = m_vld[MEM_LAT-1] ? mem_word(m_addr[MEM_LAT-1]) : 32'hDEAD_BEEF;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, output int waits);
        logic got;
        got   = 1'b0;
        waits = 0;
        exp_q.push_back(mem_word(a));
        core_req  = 1'b1;
        core_addr = a;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (core_valid) begin
                check_val($sformatf("data@%08h", a), core_data, exp_q.pop_front());
                check_val("stall_on_hit", 32'(core_stall), 32'd0);
                got = 1'b1;
                n_hits++;
            end else begin
                check_val("stall_on_wait", 32'(core_stall), 32'd1);
                waits++;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            check_val("fetch_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic fetch_run(input logic [31:0] start, input int n, output int total);
        int w;
        total = 0;
        for (int i = 0; i < n; i++) begin
            fetch(start + 32'(i * INST_BYTES), w);
            total += w;
        end
    endtask

    initial begin
        int w;
        int tot;
        int cnt;

        // Reset, with a request held to confirm stall stays low.
        rst = 1'b0; core_req = 1'b1; core_addr = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_valid", 32'(core_valid), 32'd0);
        check_val("rst_stall", 32'(core_stall), 32'd0);
        check_val("rst_data", core_data, 32'd0);
        check_val("rst_mem_en", 32'(mem_en), 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check_val("rst_redir_cnt", 32'(redir_cnt), 32'd0);
        @(posedge clk); #1;
        core_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        fetch(32'h0, w);
        n_redir++;
        check_val("first_latency", 32'(w), 32'd4);
        fetch_run(32'h4, 15, tot);
        check_val("seq_stalls", 32'(tot), 32'd0);

        // Idle the core: prefetch must stop with exactly DEPTH words outstanding.
        core_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 5) cnt += int'(mem_en);
            @(posedge clk); #1;
        end
        check_val("hold_mem_en", 32'(cnt), 32'd0);
        check_val("hold_runahead", mem_addr, 32'h40 + 32'(3 * INST_BYTES));
        fetch_run(32'h40, 8, tot);
        check_val("resume_stalls", 32'(tot), 32'd0);

        fetch(32'h100, w);
        n_redir++;
        check_val("jump_latency", 32'(w), 32'd4);
`ifdef INST_PREFETCH_STATS_EN
        check_val("jump_redir_cnt", 32'(redir_cnt), 32'(n_redir));
`else
        check_val("jump_redir_cnt", 32'(redir_cnt), 32'd0);
`endif
        fetch_run(32'h104, 3, tot);
        check_val("jump_seq_stalls", 32'(tot), 32'd0);

        // Two back-to-back redirects: only the second stream may surface.
        core_req = 1'b1; core_addr = 32'h200;
        @(negedge clk);
        check_val("dbl_first_valid", 32'(core_valid), 32'd0);
        @(posedge clk); #1;
        fetch(32'h300, w);
        n_redir += 2;
        check_val("dbl_latency", 32'(w), 32'd4);
        fetch_run(32'h304, 4, tot);
        check_val("dbl_seq_stalls", 32'(tot), 32'd0);

        // Reset mid-stream with returns in flight.
        core_req = 1'b1; core_addr = 32'h314;
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_rst_valid", 32'(core_valid), 32'd0);
        check_val("mid_rst_stall", 32'(core_stall), 32'd0);
        check_val("mid_rst_data", core_data, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("mid_rst_mem_en", 32'(mem_en), 32'd0);
        check_val("mid_rst_mem_addr", mem_addr, 32'd0);
        check_val("mid_rst_hit_cnt", 32'(hit_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; core_req = 1'b0;
        n_hits = 0; n_redir = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(mem_en) + int'(core_valid);
            @(posedge clk); #1;
        end
        check_val("post_rst_quiet", 32'(cnt), 32'd0);

        fetch(32'h0, w);
        n_redir++;
        check_val("idle_redir_latency", 32'(w), 32'd4);
        fetch(32'h4, w);
        check_val("idle_seq_wait", 32'(w), 32'd0);

        // Address wrap at the top of the map.
        fetch(32'hFFFF_FFFC, w);
        n_redir++;
        check_val("wrap_redir_latency", 32'(w), 32'd4);
        fetch_run(32'h0, 3, tot);
        check_val("wrap_seq_stalls", 32'(tot), 32'd0);
        core_req = 1'b0;

        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef INST_PREFETCH_STATS_EN
        check_val("final_hit_cnt", 32'(hit_cnt), 32'(n_hits));
        check_val("final_redir_cnt", 32'(redir_cnt), 32'(n_redir));
`else
        check_val("final_hit_cnt", 32'(hit_cnt), 32'd0);
        check_val("final_redir_cnt", 32'(redir_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
